fp_div_sched: RTL

//  Shares one single-cycle-registered IEEE754 single-precision divider among NREQ requesters.

---
 rtl/fp_div_sched_if.sv | 30 +++
 rtl/fp_div_sched.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fp_div_sched_if.sv
// rtl/fp_div_sched_if.sv - request, divider and response signals of the shared divider scheduler
interface fp_div_sched_if #(
  parameter int NREQ = 4
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_n;
  logic [NREQ*32-1:0] req_d;
  logic [NREQ-1:0]    req_ready;
  logic [31:0]        div_n;
  logic [31:0]        div_d;
  logic [31:0]        div_o;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [31:0]        rsp_data;
  logic [3:0]         rsp_flags;
  logic               busy;

  modport master (
    output req_valid, req_n, req_d, div_o, rsp_ready,
    input  req_ready, div_n, div_d, rsp_valid, rsp_id, rsp_data, rsp_flags, busy
  );

  modport slave (
    input  req_valid, req_n, req_d, div_o, rsp_ready,
    output req_ready, div_n, div_d, rsp_valid, rsp_id, rsp_data, rsp_flags, busy
  );
endinterface

// File: rtl/fp_div_sched.sv
// rtl/fp_div_sched.sv - round-robin scheduler sharing one fp32 divider, special operands bypass it
module fp_div_sched #(
  parameter int NREQ    = 4,
  parameter int DIV_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  fp_div_sched_if.slave  bus
);
  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = $clog2(DIV_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic [ID_W-1:0]   r_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_div_n, r_div_d;
  logic [ID_W-1:0]   r_rsp_id;
  logic [31:0]       r_rsp_data;
  logic [3:0]        r_rsp_flags;

  logic              w_gnt_any;
  logic [ID_W-1:0]   w_gnt_id;
  logic              w_accept;
  logic [31:0]       w_n, w_d;
  logic [7:0]        w_ne, w_de;
  logic              w_sign;
  logic              w_n_nan, w_n_inf, w_n_zero, w_d_nan, w_d_inf, w_d_zero;
  logic signed [9:0] w_exp;
  logic              w_special;
  logic [31:0]       w_spec_data;
  logic [3:0]        w_spec_flags;

  // Search starts just after the last grant so every requester gets a turn
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_gnt_any && bus.req_valid[(int'(r_ptr) + k) % NREQ]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = ID_W'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_gnt_any;

  assign w_n      = bus.req_n[32*w_gnt_id +: 32];
  assign w_d      = bus.req_d[32*w_gnt_id +: 32];
  assign w_ne     = w_n[30:23];
  assign w_de     = w_d[30:23];
  assign w_sign   = w_n[31] ^ w_d[31];
  assign w_n_nan  = (w_ne == 8'hFF) && (w_n[22:0] != 23'd0);
  assign w_n_inf  = (w_ne == 8'hFF) && (w_n[22:0] == 23'd0);
  assign w_n_zero = (w_ne == 8'h00);
  assign w_d_nan  = (w_de == 8'hFF) && (w_d[22:0] != 23'd0);
  assign w_d_inf  = (w_de == 8'hFF) && (w_d[22:0] == 23'd0);
  assign w_d_zero = (w_de == 8'h00);
  assign w_exp    = $signed({2'b00, w_ne}) - $signed({2'b00, w_de}) + 10'sd127;

  // Denormals land in the zero class because only the exponent field is tested
  always_comb begin
    w_special    = 1'b1;
    w_spec_data  = 32'd0;
    w_spec_flags = 4'b0000;
    if (w_n_nan || w_d_nan || (w_n_zero && w_d_zero) || (w_n_inf && w_d_inf)) begin
      w_spec_data  = 32'h7FC0_0000;
      w_spec_flags = 4'b1000;
    end else if (w_n_inf) begin
      w_spec_data  = {w_sign, 8'hFF, 23'd0};
    end else if (w_d_inf) begin
      w_spec_data  = {w_sign, 31'd0};
    end else if (w_d_zero) begin
      w_spec_data  = {w_sign, 8'hFF, 23'd0};
      w_spec_flags = 4'b0100;
    end else if (w_n_zero) begin
      w_spec_data  = {w_sign, 31'd0};
    end else if (w_exp > 10'sd254) begin
      w_spec_data  = {w_sign, 8'hFF, 23'd0};
      w_spec_flags = 4'b0010;
    end else if (w_exp < 10'sd4) begin
      w_spec_data  = {w_sign, 31'd0};
      w_spec_flags = 4'b0001;
    end else begin
      w_special    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_special ? S_RESP : S_EXEC;
      S_EXEC:  if (r_cnt == '0) w_state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= ID_W'(NREQ - 1);
      r_cnt       <= '0;
      r_div_n     <= 32'd0;
      r_div_d     <= 32'd0;
      r_rsp_id    <= '0;
      r_rsp_data  <= 32'd0;
      r_rsp_flags <= 4'b0000;
    end else begin
      if (w_accept) begin
        r_ptr    <= w_gnt_id;
        r_rsp_id <= w_gnt_id;
        if (w_special) begin
          r_rsp_data  <= w_spec_data;
          r_rsp_flags <= w_spec_flags;
        end else begin
          r_div_n <= w_n;
          r_div_d <= w_d;
          r_cnt   <= CNT_W'(DIV_LAT);
        end
      end
      if (r_state == S_EXEC) begin
        if (r_cnt == '0) begin
          r_rsp_data  <= bus.div_o;
          r_rsp_flags <= 4'b0000;
        end else begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
    end
  end

  // Ready is gated by reset so nothing is accepted while the block is held in reset
  assign bus.req_ready = (w_accept && rst_n) ? (NREQ'(1) << w_gnt_id) : '0;
  assign bus.div_n     = r_div_n;
  assign bus.div_d     = r_div_d;
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_flags = r_rsp_flags;
  assign bus.busy      = (r_state != S_IDLE);
endmodule
